// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer.
// Contents: sequencer state encoding (4-bit), default data width,
// request write-enable encodings and a helper that identifies the
// states waiting for a host response.
package mem_access_sequencer_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic REQ_WE_READ  = 1'b0;
   localparam logic REQ_WE_WRITE = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_F_REQ  = 4'd1,
      ST_F_WAIT = 4'd2,
      ST_DECIDE = 4'd3,
      ST_L_REQ  = 4'd4,
      ST_L_WAIT = 4'd5,
      ST_S_REQ  = 4'd6,
      ST_S_WAIT = 4'd7,
      ST_STEP   = 4'd8,
      ST_FAULT  = 4'd9
   } state_e;

   function automatic logic is_wait(input state_e s);
      return (s == ST_F_WAIT) || (s == ST_L_WAIT) || (s == ST_S_WAIT);
   endfunction

endpackage

// File: rtl/mem_access_sequencer_seq_timeout_ctr.sv
// seq_timeout_ctr: response timeout counter.
// Ports:
//   clk_sys, sys_reset_n : clock, asynchronous active-low reset
//   clr                  : force count to zero (held while not waiting)
//   en                   : count one waiting cycle
//   expired              : current cycle is the TMO_CYCLES-th waiting cycle
module seq_timeout_ctr #(
   parameter int TMO_W      = 8,
   parameter int TMO_CYCLES = 255
) (
   input  logic clk_sys,
   input  logic sys_reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   // cnt_q equals the number of waiting cycles already spent, so the
   // last allowed cycle is the one where it reads TMO_CYCLES-1.
   assign expired = (cnt_q == TMO_W'(TMO_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: steps the cpu one instruction at a time over a
// single shared host memory port (fetch, then optional load or store).
// Ports:
//   clk_sys, sys_reset_n        : clock, asynchronous active-low reset
//   run                         : keep stepping (sampled in IDLE and STEP)
//   progctr/memaddr/memdata     : cpu fetch address, data address, store data
//   memloadf/memstoref          : cpu load/store request for current instruction
//   instruction/from_memory     : captured fetch / load data to the cpu
//   cpu_step                    : one-cycle advance pulse
//   req_valid/req_ready/req_we/req_addr/req_wdata : host request channel
//   resp_valid/resp_rdata       : host response strobe and read data
//   busy, fault, step_count     : status
//   dbg_state                   : current FSM state for observation
// Handshake: a request transfers on a cycle with req_valid & req_ready;
// while req_valid is high and not accepted, req_we/req_addr/req_wdata stay
// stable (the cpu holds its inputs until cpu_step). resp_valid is only
// looked at in a *_WAIT state, i.e. from the cycle after acceptance.
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int TMO_CYCLES = 255,
   parameter int TMO_W      = 8
) (
   input  logic            clk_sys,
   input  logic            sys_reset_n,
   input  logic            run,
   input  logic [XLEN-1:0] progctr,
   input  logic [XLEN-1:0] memaddr,
   input  logic [XLEN-1:0] memdata,
   input  logic            memloadf,
   input  logic            memstoref,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] from_memory,
   output logic            cpu_step,
   output logic            req_valid,
   input  logic            req_ready,
   output logic            req_we,
   output logic [XLEN-1:0] req_addr,
   output logic [XLEN-1:0] req_wdata,
   input  logic            resp_valid,
   input  logic [XLEN-1:0] resp_rdata,
   output logic            busy,
   output logic            fault,
   output logic [XLEN-1:0] step_count,
   output logic [3:0]      dbg_state
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] instruction_q, instruction_d;
   logic [XLEN-1:0] from_memory_q, from_memory_d;
   logic [XLEN-1:0] step_count_q, step_count_d;
   logic            tmo_expired;

   seq_timeout_ctr #(
      .TMO_W      (TMO_W),
      .TMO_CYCLES (TMO_CYCLES)
   ) u_tmo (
      .clk_sys     (clk_sys),
      .sys_reset_n (sys_reset_n),
      .clr         (!is_wait(state_q)),
      .en          (is_wait(state_q)),
      .expired     (tmo_expired)
   );

   always_comb begin
      state_d       = state_q;
      instruction_d = instruction_q;
      from_memory_d = from_memory_q;
      step_count_d  = step_count_q;
      req_valid     = 1'b0;
      req_we        = REQ_WE_READ;
      req_addr      = '0;
      req_wdata     = '0;
      cpu_step      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_F_REQ;
         end
         ST_F_REQ: begin
            req_valid = 1'b1;
            req_addr  = progctr;
            if (req_ready) state_d = ST_F_WAIT;
         end
         ST_F_WAIT: begin
            // A response on the expiry cycle still wins over the timeout.
            if (resp_valid) begin
               instruction_d = resp_rdata;
               state_d       = ST_DECIDE;
            end else if (tmo_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_DECIDE: begin
            // The cpu decodes the new instruction during this cycle, so
            // its load/store flags are only meaningful here.
            case ({memloadf, memstoref})
               2'b10:   state_d = ST_L_REQ;
               2'b01:   state_d = ST_S_REQ;
               2'b00:   state_d = ST_STEP;
               default: state_d = ST_FAULT;
            endcase
         end
         ST_L_REQ: begin
            req_valid = 1'b1;
            req_addr  = memaddr;
            if (req_ready) state_d = ST_L_WAIT;
         end
         ST_L_WAIT: begin
            if (resp_valid) begin
               from_memory_d = resp_rdata;
               state_d       = ST_STEP;
            end else if (tmo_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_S_REQ: begin
            req_valid = 1'b1;
            req_we    = REQ_WE_WRITE;
            req_addr  = memaddr;
            req_wdata = memdata;
            if (req_ready) state_d = ST_S_WAIT;
         end
         ST_S_WAIT: begin
            if (resp_valid) begin
               state_d = ST_STEP;
            end else if (tmo_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_STEP: begin
            cpu_step     = 1'b1;
            step_count_d = step_count_q + 1'b1;
            state_d      = run ? ST_F_REQ : ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q       <= ST_IDLE;
         instruction_q <= '0;
         from_memory_q <= '0;
         step_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         instruction_q <= instruction_d;
         from_memory_q <= from_memory_d;
         step_count_q  <= step_count_d;
      end
   end

   assign instruction = instruction_q;
   assign from_memory = from_memory_q;
   assign step_count  = step_count_q;
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
   assign fault       = (state_q == ST_FAULT);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed testbench for mem_access_sequencer: nop stepping, load, stalled
// store, timeout edge and fault, illegal load+store, stray response,
// asynchronous reset mid-request.
module tb_mem_access_sequencer;
   import mem_access_sequencer_pkg::*;

   localparam int XLEN = 32;
   localparam int TMO  = 10;

   logic            clk_sys;
   logic            sys_reset_n;
   logic            run;
   logic [XLEN-1:0] progctr, memaddr, memdata;
   logic            memloadf, memstoref;
   logic [XLEN-1:0] instruction, from_memory;
   logic            cpu_step;
   logic            req_valid, req_ready, req_we;
   logic [XLEN-1:0] req_addr, req_wdata;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            busy, fault;
   logic [XLEN-1:0] step_count;
   logic [3:0]      dbg_state;

   int checks   = 0;
   int failures = 0;
   int cyc;
   int pulses;

   mem_access_sequencer #(.XLEN(XLEN), .TMO_CYCLES(TMO), .TMO_W(8)) dut (
      .clk_sys     (clk_sys),
      .sys_reset_n (sys_reset_n),
      .run         (run),
      .progctr     (progctr),
      .memaddr     (memaddr),
      .memdata     (memdata),
      .memloadf    (memloadf),
      .memstoref   (memstoref),
      .instruction (instruction),
      .from_memory (from_memory),
      .cpu_step    (cpu_step),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .busy        (busy),
      .fault       (fault),
      .step_count  (step_count),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Ticks until cpu_step is seen; returns the tick count, or -1 on budget expiry.
   task automatic wait_step(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (cpu_step === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      sys_reset_n = 1'b0;
      tick();
      tick();
      sys_reset_n = 1'b1;
   endtask

   initial begin
      sys_reset_n = 1'b0;
      run = 1'b0; progctr = '0; memaddr = '0; memdata = '0;
      memloadf = 1'b0; memstoref = 1'b0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;

      // reset state
      #2;
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("rst_step_count", step_count, 32'd0);
      check("rst_instruction", instruction, 32'd0);
      tick();
      sys_reset_n = 1'b1;
      tick();

      // nop stepping: ready and response immediate
      progctr = 32'h40; resp_rdata = 32'h0000_0013;
      req_ready = 1'b1; resp_valid = 1'b1; run = 1'b1;
      tick();
      check("f_req_valid", 32'(req_valid), 32'd1);
      check("f_req_addr", req_addr, 32'h40);
      check("f_req_we", 32'(req_we), 32'd0);
      check("f_req_wdata", req_wdata, 32'd0);
      check("f_busy", 32'(busy), 32'd1);
      wait_step(20, cyc);
      check("nop1_latency", cyc, 32'd3);
      check("nop1_instr", instruction, 32'h13);
      check("nop1_count", step_count, 32'd0);
      wait_step(20, cyc);
      check("nop2_period", cyc, 32'd4);
      check("nop2_count", step_count, 32'd1);
      wait_step(20, cyc);
      check("nop3_period", cyc, 32'd4);
      run = 1'b0;
      tick();
      check("nop_count3", step_count, 32'd3);
      check("nop_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("nop_idle_busy", 32'(busy), 32'd0);
      check("nop_step_low", 32'(cpu_step), 32'd0);

      // stray response in IDLE is ignored
      resp_rdata = 32'hCAFE_F00D;
      tick();
      tick();
      check("stray_instr", instruction, 32'h13);
      check("stray_from_mem", from_memory, 32'd0);
      check("stray_state", 32'(dbg_state), 32'(ST_IDLE));

      // load: fetch, then load from 0x100; run drops during L_WAIT
      progctr = 32'h44; memaddr = 32'h100; memloadf = 1'b1;
      resp_rdata = 32'h0001_2083; run = 1'b1;
      tick();                                    // F_REQ
      check("ld_fetch_addr", req_addr, 32'h44);
      tick();                                    // F_WAIT
      tick();                                    // DECIDE
      check("ld_instr", instruction, 32'h0001_2083);
      resp_rdata = 32'hDEAD_BEEF;
      tick();                                    // L_REQ
      check("ld_req_valid", 32'(req_valid), 32'd1);
      check("ld_req_addr", req_addr, 32'h100);
      check("ld_req_we", 32'(req_we), 32'd0);
      tick();                                    // L_WAIT
      check("ld_wait_state", 32'(dbg_state), 32'(ST_L_WAIT));
      run = 1'b0;
      tick();                                    // STEP at tick 6
      check("ld_pulse6", 32'(cpu_step), 32'd1);
      check("ld_from_mem", from_memory, 32'hDEAD_BEEF);
      check("ld_instr_hold", instruction, 32'h0001_2083);
      tick();
      check("ld_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("ld_count", step_count, 32'd4);
      memloadf = 1'b0;

      // store with req_ready low for 3 cycles
      progctr = 32'h48; memaddr = 32'h200; memdata = 32'h1234_5678;
      memstoref = 1'b1; resp_rdata = 32'h0011_2023; run = 1'b1;
      tick();                                    // F_REQ
      tick();                                    // F_WAIT
      tick();                                    // DECIDE
      req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();                                 // S_REQ, stalled
         check("st_valid", 32'(req_valid), 32'd1);
         check("st_we", 32'(req_we), 32'd1);
         check("st_addr", req_addr, 32'h200);
         check("st_wdata", req_wdata, 32'h1234_5678);
      end
      req_ready = 1'b1;
      resp_rdata = 32'h5555_AAAA;
      tick();                                    // S_WAIT
      check("st_wait_valid", 32'(req_valid), 32'd0);
      check("st_wait_wdata", req_wdata, 32'd0);
      run = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cpu_step === 1'b1) pulses++;
      end
      check("st_one_pulse", pulses, 32'd1);
      check("st_from_mem_hold", from_memory, 32'hDEAD_BEEF);
      check("st_count", step_count, 32'd5);
      check("st_idle", 32'(dbg_state), 32'(ST_IDLE));
      memstoref = 1'b0;

      // response on the last allowed wait cycle: no fault
      resp_valid = 1'b0; resp_rdata = 32'h13; run = 1'b1;
      tick();                                    // F_REQ
      tick();                                    // F_WAIT, wait cycle 0
      for (int i = 0; i < TMO - 1; i++) tick();  // wait cycle TMO-1
      check("tmo_edge_state", 32'(dbg_state), 32'(ST_F_WAIT));
      check("tmo_edge_fault", 32'(fault), 32'd0);
      resp_valid = 1'b1;
      tick();
      check("tmo_edge_decide", 32'(dbg_state), 32'(ST_DECIDE));
      check("tmo_edge_nofault", 32'(fault), 32'd0);
      run = 1'b0;
      tick();                                    // STEP
      tick();                                    // IDLE
      check("tmo_edge_count", step_count, 32'd6);

      // no response for TMO wait cycles: fault
      resp_valid = 1'b0; run = 1'b1;
      tick();                                    // F_REQ
      tick();                                    // F_WAIT
      for (int i = 0; i < TMO - 1; i++) tick();
      check("tmo_pre_fault", 32'(fault), 32'd0);
      tick();
      check("tmo_fault", 32'(fault), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_req_valid", 32'(req_valid), 32'd0);
      resp_valid = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cpu_step === 1'b1) pulses++;
      end
      check("fault_no_step", pulses, 32'd0);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_count", step_count, 32'd6);

      // reset clears the fault
      run = 1'b0;
      do_reset();
      check("clr_fault", 32'(fault), 32'd0);
      check("clr_count", step_count, 32'd0);

      // load and store requested together: fault after DECIDE
      memloadf = 1'b1; memstoref = 1'b1; resp_rdata = 32'h13; run = 1'b1;
      tick();                                    // F_REQ
      tick();                                    // F_WAIT
      tick();                                    // DECIDE
      check("both_decide", 32'(dbg_state), 32'(ST_DECIDE));
      check("both_nofault_yet", 32'(fault), 32'd0);
      tick();
      check("both_fault", 32'(fault), 32'd1);
      check("both_state", 32'(dbg_state), 32'(ST_FAULT));

      // asynchronous reset during S_REQ
      run = 1'b0;
      do_reset();
      memloadf = 1'b0; memstoref = 1'b1; resp_rdata = 32'h0011_2023; run = 1'b1;
      tick();                                    // F_REQ
      tick();                                    // F_WAIT
      tick();                                    // DECIDE
      req_ready = 1'b0;
      tick();                                    // S_REQ
      check("ar_pre_valid", 32'(req_valid), 32'd1);
      check("ar_pre_instr", instruction, 32'h0011_2023);
      #2 sys_reset_n = 1'b0;
      #1;
      check("ar_req_valid", 32'(req_valid), 32'd0);
      check("ar_req_we", 32'(req_we), 32'd0);
      check("ar_req_addr", req_addr, 32'd0);
      check("ar_req_wdata", req_wdata, 32'd0);
      check("ar_instr", instruction, 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_state", 32'(dbg_state), 32'(ST_IDLE));
      run = 1'b0;
      tick();
      sys_reset_n = 1'b1;
      tick();
      check("ar_after_idle", 32'(dbg_state), 32'(ST_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
